// File: rtl/dpram_stream_reader_pkg.sv
// Shared types and constants for the dual-port RAM stream reader.
package dpram_pkg;

    // Sequencer state: waiting for a command, or streaming a block.
    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    // Words the output buffer can hold; the read credit check is sized to it.
    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/dpram_stream_reader_fifo2.sv
// Two-entry register FIFO. Entry 0 is always the head, so dout is a plain
// register with no read mux. Push while full is ignored unless a pop frees
// a slot in the same cycle.
module fifo2
    import dpram_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] ent0, ent1;
    logic [1:0]   cnt;
    logic         do_pop, do_push;

    assign empty   = (cnt == 2'd0);
    assign full    = (cnt == 2'(BUF_DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = ent0;

    // Shift-style storage: pops move entry 1 forward, pushes fill the first free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0 <= '0;
            ent1 <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) ent0 <= din;
                    else             ent1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        ent0 <= din;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dpram_stream_reader.sv
// Streams a block of consecutive RAM words onto a valid/ready interface.
// Reads are only issued when the output buffer is guaranteed a free slot
// for the returning word, so the 1-cycle RAM latency never causes a drop.
module dpram_stream_reader
    import dpram_pkg::*;
#(
    parameter int width   = 1,
    parameter int widthad = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [widthad-1:0] start_addr,
    input  logic [widthad:0]   len,
    output logic               busy,
    output logic               done,
    output logic               rden,
    output logic [widthad-1:0] rdaddress,
    input  logic [width-1:0]   q,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [width-1:0]   m_data,
    output logic               m_last
);

    state_t             state;
    logic [widthad:0]   issue_cnt;
    logic [widthad:0]   pop_cnt;
    logic               inflight;
    logic               inflight_last;
    logic               pop;
    logic               buf_full, buf_empty;
    logic [1:0]         occ, used, limit;
    logic [width:0]     buf_dout;

    // Credit check: buffered + in-flight words, less the one leaving now,
    // must stay below the buffer depth before another read may go out.
    // m_ready reaches rden combinationally through pop.
    assign pop   = m_valid & m_ready;
    assign occ   = buf_full ? 2'd2 : (buf_empty ? 2'd0 : 2'd1);
    assign used  = occ + {1'b0, inflight};
    assign limit = 2'(BUF_DEPTH) + {1'b0, pop};
    assign rden  = (state == READ) && (issue_cnt != '0) && (used < limit);

    assign busy    = (state == READ);
    assign m_valid = ~buf_empty;
    assign m_data  = buf_dout[width-1:0];
    assign m_last  = buf_dout[width];

    // Returning RAM word plus its last-word tag enter the buffer together.
    fifo2 #(
        .W(width + 1)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .pop   (pop),
        .din   ({inflight_last, q}),
        .dout  (buf_dout),
        .full  (buf_full),
        .empty (buf_empty)
    );

    // Command FSM with issue/accept counters and the in-flight read tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rdaddress     <= '0;
            issue_cnt     <= '0;
            pop_cnt       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= rden;
            inflight_last <= rden && (issue_cnt == {{widthad{1'b0}}, 1'b1});
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= READ;
                            rdaddress <= start_addr;
                            issue_cnt <= len;
                            pop_cnt   <= len;
                        end
                    end
                end
                READ: begin
                    if (rden) begin
                        rdaddress <= rdaddress + 1'b1;
                        issue_cnt <= issue_cnt - 1'b1;
                    end
                    if (pop) begin
                        pop_cnt <= pop_cnt - 1'b1;
                        if (pop_cnt == {{widthad{1'b0}}, 1'b1}) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed bench for dpram_stream_reader: a table of transfers with
// per-word data/last/address/timing checks, a continuous credit and
// stall-stability monitor, plus zero-length and reset-mid-transfer sequences.
module tb_dpram_stream_reader;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, rden;
    logic [AW-1:0] rdaddress;
    logic [W-1:0]  q = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_data;
    logic          m_last;

    always #5 clk = ~clk;

    dpram_stream_reader #(
        .width   (W),
        .widthad (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .rden       (rden),
        .rdaddress  (rdaddress),
        .q          (q),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    // RAM read port model: registered read, one cycle latency.
    logic [W-1:0] mem [16];
    always @(posedge clk) if (rden) q <= mem[rdaddress];

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rden"}, rden, 0);
        chk({tag, "_rdaddress"}, rdaddress, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_m_last"}, m_last, 0);
    endtask

    // Independent occupancy model: words buffered and reads in flight.
    int   mocc = 0;
    logic minfl = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mocc  <= 0;
            minfl <= 1'b0;
        end else begin
            mocc  <= mocc + int'(minfl) - int'(m_valid & m_ready);
            minfl <= rden;
        end
    end

    logic         pstall = 1'b0;
    logic [W-1:0] pdata = '0;
    logic         plast = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pstall = 1'b0;
        end else begin
            chk("occ_le_2", mocc <= 2, 1);
            chk("valid_vs_occ", m_valid, mocc != 0);
            if (rden) chk("rden_credit", (mocc + int'(minfl) - int'(m_valid & m_ready)) < 2, 1);
            if (pstall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, pdata);
                chk("stall_last", m_last, plast);
            end
            pstall = m_valid & ~m_ready;
            pdata  = m_data;
            plast  = m_last;
        end
    end

    typedef struct {
        logic [AW-1:0] sa;
        logic [AW:0]   len;
        logic [15:0]   pat;   // m_ready pattern, bit (cycle % plen)
        int            plen;
        int            poke;  // cycle at which a stray start is pulsed, 0 = none
    } vec_t;

    vec_t  tbl [7];
    string nms [7];

    // Issue start now, then follow the transfer until the done cycle.
    // Returns positioned in the done cycle (after its falling edge).
    task automatic run_xfer(input vec_t v, input string nm);
        int cyc, k, ni, first, e;
        bit fin;
        start      = 1'b1;
        start_addr = v.sa;
        len        = v.len;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; ni = 0; first = -1; fin = 1'b0;
        for (cyc = 1; cyc < 300 && !fin; cyc++) begin
            m_ready = v.pat[cyc % v.plen];
            if (cyc == v.poke) begin
                start = 1'b1; start_addr = 4'd10; len = 5'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (cyc == 1) chk({nm, "_busy_rise"}, busy, 1);
            if (k == int'(v.len)) begin
                chk({nm, "_done"}, done, 1);
                chk({nm, "_busy_fall"}, busy, 0);
                chk({nm, "_idle_rden"}, rden, 0);
                fin = 1'b1;
            end else begin
                chk({nm, "_no_early_done"}, done, 0);
                if (rden) begin
                    chk({nm, "_rdaddress"}, rdaddress, (int'(v.sa) + ni) % 16);
                    ni++;
                end
                if (m_valid && first < 0) begin
                    first = cyc;
                    chk({nm, "_latency"}, cyc, 3);
                end
                if (m_valid && m_ready) begin
                    e = (int'(v.sa) + k) % 16;
                    chk({nm, "_data"}, m_data, e);
                    chk({nm, "_last"}, m_last, k == int'(v.len) - 1);
                    if (v.plen == 1 && v.pat[0]) chk({nm, "_throughput"}, cyc, 3 + k);
                    k++;
                end
            end
            if (!fin) begin
                @(posedge clk); #1;
            end
        end
        chk({nm, "_completed"}, fin, 1);
        chk({nm, "_issue_count"}, ni, v.len);
        start = 1'b0;
    endtask

    initial begin
        int got;
        for (int i = 0; i < 16; i++) mem[i] = W'(i);

        tbl[0] = '{4'd3,  5'd5,  16'h0001,    1, 0}; nms[0] = "basic";
        tbl[1] = '{4'd14, 5'd4,  16'h0001,    1, 0}; nms[1] = "wrap";
        tbl[2] = '{4'd0,  5'd6,  16'b101001,  6, 0}; nms[2] = "bp_toggle";
        tbl[3] = '{4'd5,  5'd16, 16'h0001,    1, 0}; nms[3] = "len16";
        tbl[4] = '{4'd2,  5'd4,  16'h0001,    1, 4}; nms[4] = "start_busy";
        tbl[5] = '{4'd9,  5'd3,  16'b10,      2, 0}; nms[5] = "bp_alt";
        tbl[6] = '{4'd12, 5'd7,  16'b1000,    4, 0}; nms[6] = "bp_heavy";

        #12;
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back: each transfer starts in the previous one's done cycle.
        for (int i = 0; i < 7; i++) run_xfer(tbl[i], nms[i]);

        // Zero length: done only, no reads, no busy.
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; start_addr = 4'd7; len = 5'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_rden", rden, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("len0_done_clear", done, 0);
        chk("len0_rden_after", rden, 0);

        // Reset after two of eight words have been accepted.
        @(posedge clk); #1;
        m_ready = 1'b1;
        start = 1'b1; start_addr = 4'd0; len = 5'd8;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) got++;
            if (got < 2) begin
                @(posedge clk); #1;
            end
        end
        chk("rst_mid_two_words", got, 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_zero("rst_release");
        run_xfer(tbl[0], "post_reset");

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dpram_stream_reader.md
# dpram_stream_reader

Read-side sequencer for a `simple_dpram` instance. On a `start` command it streams a block of `len` consecutive words from the RAM read port, beginning at `start_addr`, onto a valid/ready output stream. It absorbs the RAM's one-cycle registered read latency and downstream backpressure without dropping or duplicating words. It sits between a RAM filled by a writer and any streaming consumer: packet egress, DMA, or a framer.

## Interface
- `width`, default 1: RAM data width; also the stream data width.
- `widthad`, default 1: RAM address width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  command strobe; sampled only while `busy`=0.
- `start_addr`  in  widthad  first word address.
- `len`  in  widthad+1  number of words, 0..2^widthad.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `rden`  out  1  to the RAM `rden`.
- `rdaddress`  out  widthad  to the RAM `rdaddress`.
- `q`  in  width  from the RAM `q`; valid the cycle after `rden`.
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  downstream ready.
- `m_data`  out  width  stream word.
- `m_last`  out  1  marks the final word of the transfer.

## Operation
- **State machine:**
  - IDLE → READ on `start`=1 with `len`≠0.
  - `start` with `len`=0: no state change, `done` pulses next cycle.
  - READ → IDLE when all `len` words are accepted (`m_valid`&`m_ready` on the word with `m_last`=1).
- **Counters on `start`:**
  - `rdaddress` ← `start_addr`.
  - issue_cnt ← `len`.
  - pop_cnt ← `len`.
- **Read issue:**
  - `rden` = READ && issue_cnt≠0 && (occupancy + inflight − pop) < 2.
  - pop = `m_valid`&`m_ready`.
  - This is a combinational path from `m_ready` to `rden`.
- **On each issue:** `rdaddress` increments modulo 2^widthad (wraps 2^widthad−1 → 0), and issue_cnt decrements.
- **inflight:** 1-bit register, set to `rden` each cycle. When set, `q` is pushed into the 2-entry output buffer on that cycle.
- **Last-word tag:** carried with the inflight flag; set when the issued read had issue_cnt==1.
- **Output stream:**
  - `m_data`/`m_last` come from the buffer head.
  - `m_valid` = buffer non-empty.
  - Once `m_valid` is high, `m_data`/`m_valid` stay stable until accepted.
- **Overflow:** the buffer never overflows by construction. Verification asserts occupancy ≤ 2.
- **`start` while `busy`:** ignored, no side effects.
- **Simultaneous `done` and `start`:** `busy` is already 0 in the `done` cycle, so a new `start` there is accepted.
- **Reset (any time, including mid-transfer):**
  - All state clears immediately.
  - All outputs go to 0: `busy`, `done`, `rden`, `rdaddress`, `m_valid`, `m_data`, `m_last`.
  - Buffered and inflight words are discarded.

## Timing
- **`start` sampled at edge N:**
  - `busy`=1 and first `rden`=1 in cycle N+1.
  - `q` valid in N+2, pushed at the end of N+2.
  - `m_valid`=1 from N+3. First-word latency is 3 cycles.
- **Throughput:** with `m_ready` held 1, one word per cycle. A transfer of L words shows `m_valid` in cycles N+3 .. N+2+L.
- **Backpressure:** `m_ready`=0 stops issue within one cycle. At most 2 words are held, and streaming resumes one word per cycle as soon as `m_ready` returns.
- **`done`:** pulses in the cycle after the last handshake; `busy` falls in that same cycle.

## Structure
- Shared package `dpram_pkg`:
  - state enum {IDLE, READ}.
  - Constant for the output buffer depth (2).
- Sub-module `fifo2`: a 2-entry register FIFO with push, pop, full, empty, and a `width+1` data path (data plus last). It is reusable across the codebase.
- The top level holds the FSM, counters, and issue/credit logic.

## Test plan
- **Basic transfer:** width=8, widthad=4, RAM preloaded mem[i]=i; `start_addr`=3, `len`=5, `m_ready`=1.
  - Words 3,4,5,6,7 in consecutive cycles starting at N+3.
  - `m_last` on 7; `done` one cycle after.
- **Wrap:** `start_addr`=14, `len`=4.
  - Words 14,15,0,1; `rdaddress` wraps to 0.
- **Backpressure:** `len`=6, `m_ready` toggling 1,0,0,1,0,1…
  - All 6 words in order, no duplicates.
  - `m_data` stable while stalled; `rden` never issues with occupancy+inflight−pop ≥ 2.
- **Edge lengths:**
  - `len`=0: `done` only, no `rden`.
  - `len`=16 from address 5: all 16 words, ending at 4.
  - `start` pulsed mid-transfer: ignored.
- **Reset mid-transfer:** assert `rst_n`=0 after 2 of 8 words.
  - All outputs 0 immediately.
  - A new transfer after release behaves as in the basic-transfer scenario.
